execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have parameter MISALIGN_CHECK, default 1; when 1, a jump target with bit 1 set marks the instruction illegal.
REQ-002 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have ports valid_i (input, 1) and ready_o (output, 1): slave handshake from the decode stage.
REQ-005 SHALL have inputs pc_i, inst_i, r0data_i, r1data_i, each 32 bits: PC, instruction word, rs1 value, rs2 value.
REQ-006 SHALL have ports valid_ro (output, 1) and ready_i (input, 1): master handshake to the memory stage.
REQ-007 SHALL have 32-bit registered outputs pc_ro, inst_ro, result_ro and store_data_ro, plus 1-bit registered output illegal_ro.
REQ-008 SHALL have combinational outputs jump_taken_o (1 bit) and jump_pc_o (32 bits): redirect to fetch and decode.

Function
REQ-009 SHALL define cke = ~valid_ro | ready_i; ready_o = cke & (state == IDLE).
REQ-010 SHALL accept an instruction when valid_i & ready_o; on cke, SHALL load valid_ro <= valid_i & ready_o.
REQ-011 SHALL, on acceptance, register pc_i, inst_i, result and illegal flag; store_data_ro <= r1data_i; latency one cycle.
REQ-012 SHALL compute result per opcode:
- OP/OPIMM: RV32I ALU result, shift amount = operand[4:0].
- LUI: U-immediate.
- AUIPC: pc_i + U-immediate.
- JAL/JALR: pc_i + 4.
- LOAD/STORE: r0data_i + sign-extended immediate.
- BRANCH: 0.
All arithmetic SHALL be 32-bit modulo 2^32.
REQ-013 SHALL assert jump_taken_o only in the accept cycle of a legal JAL, a legal JALR, or a taken BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU).
REQ-014 SHALL drive jump_pc_o as follows, and 0 when jump_taken_o = 0:
- JAL and BRANCH: pc_i + immediate.
- JALR: (r0data_i + imm) & ~1.
REQ-015 SHALL mark an instruction illegal on any of:
- unknown opcode;
- OP funct7 not in {0x00, 0x20};
- 0x20 with funct3 other than ADD/SRL;
- BRANCH funct3 2 or 3;
- misaligned target (REQ-001).
An illegal instruction SHALL pass downstream with illegal_ro = 1 and SHALL never jump.
REQ-016 SHALL hold all output registers unchanged while cke = 0.

Reset
REQ-017 SHALL, on rst, clear all outputs to 0, set state to IDLE, and immediately drop any in-flight multiply.

Configuration
REQ-018 With EXECUTE_MUL_EN defined, SHALL implement an FSM with states IDLE and MUL:
- OP with funct7 0x01 and funct3 0-3 (MUL/MULH/MULHSU/MULHU) SHALL be accepted in IDLE, latch its operands and enter MUL.
- In MUL, ready_o = 0; on cke, SHALL register the product (low or high 32 bits per funct3) with valid_ro = 1 and return to IDLE.
- funct3 4-7 SHALL be illegal.
REQ-019 Without EXECUTE_MUL_EN, the state SHALL remain IDLE permanently, and funct7 0x01 SHALL be illegal.

Structure
REQ-020 Opcode and funct constants and instruction field ranges SHALL live in the shared opcode/instruction-definition package.
REQ-021 A purely combinational sub-module exec_alu (operands, funct3, alt bit -> 32-bit result) SHALL hold the ALU; branch compare and FSM remain in execute.

Verification
REQ-022 ADDI x1,x0,5 (0x00500093), r0data_i = 0 -> next cycle valid_ro = 1, result_ro = 5, illegal_ro = 0.
REQ-023 BEQ +8 (0x00208463), pc_i = 0x100, r0 = r1 = 7 -> same cycle jump_taken_o = 1, jump_pc_o = 0x108; with r1 = 8 -> jump_taken_o = 0.
REQ-024 JALR x1,0(x2), pc_i = 0x40, r0data_i = 0x1001 -> jump_pc_o = 0x1000, result_ro = 0x44; with r0data_i = 0x1003 and MISALIGN_CHECK = 1 -> illegal_ro = 1, no jump.
REQ-025 valid_ro = 1, ready_i = 0, valid taken branch at input -> ready_o = 0, jump_taken_o = 0, outputs stable for 3 cycles; ready_i rises -> branch accepted.
REQ-026 MULH with EXECUTE_MUL_EN, r0 = 0xFFFFFFFF, r1 = 2 -> ready_o low one cycle, result_ro = 0xFFFFFFFF; MUL -> 0xFFFFFFFE; rst asserted in MUL -> IDLE, valid_ro = 0; without the macro -> illegal_ro = 1.
REQ-027 inst_i = 0x0000007F -> illegal_ro = 1, jump_taken_o = 0, result_ro = 0.

Source files
------------

// File: rtl/execute_pkg.sv
// Shared opcode and instruction-field definitions for the execute stage.
// Optional multiplier support is enabled by defining EXECUTE_MUL_EN.
package execute_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic {IDLE, MUL} exec_state_e;

    function automatic logic [6:0] get_opcode(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [2:0] get_funct3(input logic [31:0] inst);
        return inst[14:12];
    endfunction

    function automatic logic [6:0] get_funct7(input logic [31:0] inst);
        return inst[31:25];
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational RV32I integer ALU; alt selects SUB and SRA.
module exec_alu
    import execute_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  funct3,
    input  logic        alt,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (funct3)
            F3_ADD:  result = alt ? (a - b) : (a + b);
            F3_SLL:  result = a << b[4:0];
            F3_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            F3_SLTU: result = {31'b0, a < b};
            F3_XOR:  result = a ^ b;
            F3_SR:   result = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            F3_OR:   result = a | b;
            F3_AND:  result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// Execute stage: ALU, branch resolution and jump redirect with a registered
// output stage. Defining EXECUTE_MUL_EN adds a two-cycle MUL/MULH* path.
module execute
    import execute_pkg::*;
#(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] r0data_i,
    input  logic [31:0] r1data_i,
    output logic        valid_ro,
    input  logic        ready_i,
    output logic [31:0] pc_ro,
    output logic [31:0] inst_ro,
    output logic [31:0] result_ro,
    output logic [31:0] store_data_ro,
    output logic        illegal_ro,
    output logic        jump_taken_o,
    output logic [31:0] jump_pc_o
);

`ifdef EXECUTE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // Handshake: a word moves on either side only when valid and ready are
    // both high at a rising clk edge; cke stalls the whole output register.
    exec_state_e state;
    logic        cke;
    logic        accept;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] alu_b;
    logic        alu_alt;
    logic [31:0] alu_result;
    logic [31:0] result;
    logic        illegal;
    logic        want_jump;
    logic        branch_taken;
    logic [31:0] target;
    logic        mul_op;
    logic [31:0] mul_result;

    assign cke     = ~valid_ro | ready_i;
    assign ready_o = cke & (state == IDLE);
    assign accept  = valid_i & ready_o;

    assign opcode  = get_opcode(inst_i);
    assign funct3  = get_funct3(inst_i);
    assign funct7  = get_funct7(inst_i);
    assign alu_b   = (opcode == OPC_OP) ? r1data_i : imm_i(inst_i);
    assign alu_alt = inst_i[30] & ((opcode == OPC_OP) | (funct3 == F3_SR));

    exec_alu u_alu (
        .a      (r0data_i),
        .b      (alu_b),
        .funct3 (funct3),
        .alt    (alu_alt),
        .result (alu_result)
    );

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            F3_BEQ:  branch_taken = (r0data_i == r1data_i);
            F3_BNE:  branch_taken = (r0data_i != r1data_i);
            F3_BLT:  branch_taken = ($signed(r0data_i) < $signed(r1data_i));
            F3_BGE:  branch_taken = ($signed(r0data_i) >= $signed(r1data_i));
            F3_BLTU: branch_taken = (r0data_i < r1data_i);
            F3_BGEU: branch_taken = (r0data_i >= r1data_i);
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        result    = '0;
        illegal   = 1'b0;
        want_jump = 1'b0;
        target    = '0;
        mul_op    = 1'b0;
        case (opcode)
            OPC_OP: begin
                result = alu_result;
                if (MUL_EN && funct7 == F7_MULDIV && !funct3[2])
                    mul_op = 1'b1;
                else if (!(funct7 == F7_BASE ||
                           (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR))))
                    illegal = 1'b1;
            end
            OPC_OPIMM: result = alu_result;
            OPC_LUI:   result = imm_u(inst_i);
            OPC_AUIPC: result = pc_i + imm_u(inst_i);
            OPC_JAL: begin
                result    = pc_i + 32'd4;
                target    = pc_i + imm_j(inst_i);
                want_jump = 1'b1;
            end
            OPC_JALR: begin
                result    = pc_i + 32'd4;
                target    = (r0data_i + imm_i(inst_i)) & ~32'd1;
                want_jump = 1'b1;
            end
            OPC_LOAD:  result = r0data_i + imm_i(inst_i);
            OPC_STORE: result = r0data_i + imm_s(inst_i);
            OPC_BRANCH: begin
                target    = pc_i + imm_b(inst_i);
                want_jump = branch_taken;
                illegal   = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            default: illegal = 1'b1;
        endcase
        // Only a target that would actually be followed is checked for alignment.
        if (MISALIGN_CHECK && want_jump && target[1])
            illegal = 1'b1;
        if (illegal) begin
            result    = '0;
            want_jump = 1'b0;
            mul_op    = 1'b0;
        end
    end

    assign jump_taken_o = accept & want_jump;
    assign jump_pc_o    = jump_taken_o ? target : '0;

`ifdef EXECUTE_MUL_EN
    logic [31:0]        mul_a;
    logic [31:0]        mul_b;
    logic [1:0]         mul_sel;
    logic signed [63:0] mul_pa;
    logic signed [63:0] mul_pb;
    logic signed [63:0] product;

    // sel 1 = MULH (both signed), 2 = MULHSU (rs1 signed), 3 = MULHU.
    always_comb begin
        mul_pa     = {{32{mul_a[31] & (mul_sel == 2'd1 || mul_sel == 2'd2)}}, mul_a};
        mul_pb     = {{32{mul_b[31] & (mul_sel == 2'd1)}}, mul_b};
        product    = mul_pa * mul_pb;
        mul_result = (mul_sel == 2'd0) ? product[31:0] : product[63:32];
    end
`else
    assign mul_result = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            valid_ro      <= 1'b0;
            pc_ro         <= '0;
            inst_ro       <= '0;
            result_ro     <= '0;
            store_data_ro <= '0;
            illegal_ro    <= 1'b0;
`ifdef EXECUTE_MUL_EN
            mul_a         <= '0;
            mul_b         <= '0;
            mul_sel       <= '0;
`endif
        end else if (cke) begin
            if (state == MUL) begin
                valid_ro   <= 1'b1;
                result_ro  <= mul_result;
                illegal_ro <= 1'b0;
                state      <= IDLE;
            end else if (accept) begin
                pc_ro         <= pc_i;
                inst_ro       <= inst_i;
                store_data_ro <= r1data_i;
                illegal_ro    <= illegal;
                if (mul_op) begin
                    valid_ro  <= 1'b0;
                    result_ro <= '0;
`ifdef EXECUTE_MUL_EN
                    state     <= MUL;
                    mul_a     <= r0data_i;
                    mul_b     <= r1data_i;
                    mul_sel   <= funct3[1:0];
`endif
                end else begin
                    valid_ro  <= 1'b1;
                    result_ro <= result;
                end
            end else begin
                valid_ro <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed cases plus randomized traffic
// against a mnemonic-level reference model and an expected-output queue.
module tb_execute;

    localparam bit MIS = 1'b1;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic [31:0] r0data_i;
    logic [31:0] r1data_i;
    logic        valid_ro;
    logic        ready_i;
    logic [31:0] pc_ro;
    logic [31:0] inst_ro;
    logic [31:0] result_ro;
    logic [31:0] store_data_ro;
    logic        illegal_ro;
    logic        jump_taken_o;
    logic [31:0] jump_pc_o;

    execute #(.MISALIGN_CHECK(MIS)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .pc_i          (pc_i),
        .inst_i        (inst_i),
        .r0data_i      (r0data_i),
        .r1data_i      (r1data_i),
        .valid_ro      (valid_ro),
        .ready_i       (ready_i),
        .pc_ro         (pc_ro),
        .inst_ro       (inst_ro),
        .result_ro     (result_ro),
        .store_data_ro (store_data_ro),
        .illegal_ro    (illegal_ro),
        .jump_taken_o  (jump_taken_o),
        .jump_pc_o     (jump_pc_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [128:0] exp_q[$];
    bit mon_en   = 1'b0;
    bit mul_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit alt,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic void ref_model(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output bit ill,
                                      output bit jt, output logic [31:0] jpc,
                                      output bit is_mul);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] ii, is, ib, iu, ij;
        logic [63:0] p;
        longint      sa, sb;
        op = inst[6:0];
        f3 = inst[14:12];
        f7 = inst[31:25];
        ii = 32'($signed(inst[31:20]));
        is = 32'($signed({inst[31:25], inst[11:7]}));
        ib = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        iu = {inst[31:12], 12'h000};
        ij = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        res = '0; ill = 1'b0; jt = 1'b0; jpc = '0; is_mul = 1'b0;
        case (op)
            7'h37: res = iu;
            7'h17: res = pc + iu;
            7'h6F: begin res = pc + 4; jt = 1'b1; jpc = pc + ij; end
            7'h67: begin res = pc + 4; jt = 1'b1; jpc = (a + ii) & 32'hFFFF_FFFE; end
            7'h03: res = a + ii;
            7'h23: res = a + is;
            7'h13: res = ref_alu(f3, (f3 == 3'd5) && inst[30], a, ii);
            7'h63: begin
                jpc = pc + ib;
                case (f3)
                    3'd0: jt = (a == b);
                    3'd1: jt = (a != b);
                    3'd4: jt = ($signed(a) < $signed(b));
                    3'd5: jt = ($signed(a) >= $signed(b));
                    3'd6: jt = (a < b);
                    3'd7: jt = (a >= b);
                    default: ill = 1'b1;
                endcase
            end
            7'h33: begin
`ifdef EXECUTE_MUL_EN
                if (f7 == 7'h01 && f3 < 3'd4) begin
                    is_mul = 1'b1;
                    sa = (f3 == 3'd1 || f3 == 3'd2) ? longint'($signed(a)) : longint'({32'b0, a});
                    sb = (f3 == 3'd1) ? longint'($signed(b)) : longint'({32'b0, b});
                    p = 64'(sa * sb);
                    res = (f3 == 3'd0) ? p[31:0] : p[63:32];
                end else
`endif
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
                    res = ref_alu(f3, f7 == 7'h20, a, b);
                else
                    ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (jt && MIS && jpc[1]) ill = 1'b1;
        if (ill) begin res = '0; jt = 1'b0; jpc = '0; is_mul = 1'b0; end
    endfunction

    // ---------------- monitor ----------------
    logic [128:0] m_e;
    logic [31:0]  m_res, m_jpc;
    bit           m_ill, m_jt, m_mul, m_acc, m_rdy;

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_ro && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    check("out_pc",      pc_ro,         m_e[128:97]);
                    check("out_inst",    inst_ro,       m_e[96:65]);
                    check("out_result",  result_ro,     m_e[64:33]);
                    check("out_store",   store_data_ro, m_e[32:1]);
                    check("out_illegal", 32'(illegal_ro), 32'(m_e[0]));
                end
            end
            m_rdy = (!valid_ro || ready_i) && !mul_busy;
            check("ready", 32'(ready_o), 32'(m_rdy));
            ref_model(pc_i, inst_i, r0data_i, r1data_i, m_res, m_ill, m_jt, m_jpc, m_mul);
            m_acc = valid_i && m_rdy;
            check("jump_taken", 32'(jump_taken_o), 32'(m_acc && m_jt));
            check("jump_pc", jump_pc_o, (m_acc && m_jt) ? m_jpc : 32'd0);
            if (m_acc) exp_q.push_back({pc_i, inst_i, m_res, r1data_i, m_ill});
            mul_busy = m_acc && m_mul;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] a, input logic [31:0] b);
        valid_i  = v;
        pc_i     = pc;
        inst_i   = inst;
        r0data_i = a;
        r1data_i = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] x;
        logic [6:0]  f7;
        x = $urandom;
        case ($urandom_range(0, 9))
            0: begin
                x[6:0] = 7'h33;
                case ($urandom_range(0, 3))
                    0: f7 = 7'h00;
                    1: f7 = 7'h20;
                    2: f7 = 7'h01;
                    default: f7 = 7'($urandom);
                endcase
                x[31:25] = f7;
            end
            1: x[6:0] = 7'h13;
            2: x[6:0] = 7'h37;
            3: x[6:0] = 7'h17;
            4: x[6:0] = 7'h6F;
            5: x[6:0] = 7'h67;
            6: x[6:0] = 7'h03;
            7: x[6:0] = 7'h23;
            8: x[6:0] = 7'h63;
            default: x[6:0] = 7'($urandom);
        endcase
        return x;
    endfunction

    // ---------------- stimulus ----------------
    logic [31:0] r_pc, r_a;

    initial begin
        set_in(1'b0, '0, '0, '0, '0);
        ready_i = 1'b1;
        rst     = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid",  32'(valid_ro),     32'd0);
        check("rst_result", result_ro,         32'd0);
        check("rst_pc",     pc_ro,             32'd0);
        check("rst_illegal", 32'(illegal_ro),  32'd0);
        do_reset();
        check("rst_ready", 32'(ready_o), 32'd1);

        // ADDI x1,x0,5
        set_in(1'b1, 32'h0, 32'h00500093, 32'd0, 32'd0);
        tick();
        valid_i = 1'b0;
        check("addi_valid",   32'(valid_ro),   32'd1);
        check("addi_result",  result_ro,       32'd5);
        check("addi_illegal", 32'(illegal_ro), 32'd0);

        // BEQ +8, taken then not taken
        set_in(1'b1, 32'h100, 32'h00208463, 32'd7, 32'd7);
        @(negedge clk);
        check("beq_taken", 32'(jump_taken_o), 32'd1);
        check("beq_pc",    jump_pc_o,         32'h108);
        r1data_i = 32'd8;
        #1;
        check("beq_not_taken", 32'(jump_taken_o), 32'd0);
        check("beq_nt_pc",     jump_pc_o,         32'd0);
        tick();
        check("beq_result", result_ro, 32'd0);

        // JALR x1,0(x2), aligned then misaligned target
        set_in(1'b1, 32'h40, 32'h000100E7, 32'h1001, 32'd0);
        @(negedge clk);
        check("jalr_taken", 32'(jump_taken_o), 32'd1);
        check("jalr_pc",    jump_pc_o,         32'h1000);
        tick();
        check("jalr_result", result_ro, 32'h44);
        r0data_i = 32'h1003;
        @(negedge clk);
        check("jalr_mis_jump", 32'(jump_taken_o), 32'd0);
        tick();
        check("jalr_mis_illegal", 32'(illegal_ro), 32'd1);

        // Unknown opcode
        set_in(1'b1, 32'h200, 32'h0000007F, 32'h1234, 32'h5678);
        @(negedge clk);
        check("bad_jump", 32'(jump_taken_o), 32'd0);
        tick();
        check("bad_illegal", 32'(illegal_ro), 32'd1);
        check("bad_result",  result_ro,       32'd0);
        check("bad_store",   store_data_ro,   32'h5678);

        // Back-pressure: held output must not change, branch waits
        valid_i = 1'b0;
        tick();
        set_in(1'b1, 32'h80, 32'h00500093, 32'd0, 32'd0);
        ready_i = 1'b0;
        tick();
        set_in(1'b1, 32'h100, 32'h00208463, 32'd7, 32'd7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_ready",  32'(ready_o),      32'd0);
            check("stall_jump",   32'(jump_taken_o), 32'd0);
            check("stall_valid",  32'(valid_ro),     32'd1);
            check("stall_result", result_ro,         32'd5);
            check("stall_pc",     pc_ro,             32'h80);
            tick();
        end
        ready_i = 1'b1;
        @(negedge clk);
        check("resume_jump", 32'(jump_taken_o), 32'd1);
        check("resume_pc",   jump_pc_o,         32'h108);
        tick();
        valid_i = 1'b0;
        check("resume_inst", inst_ro, 32'h00208463);

`ifdef EXECUTE_MUL_EN
        // MULH -1 * 2, then MUL, then reset while busy
        set_in(1'b1, 32'h300, 32'h022091B3, 32'hFFFF_FFFF, 32'd2);
        @(negedge clk);
        check("mulh_ready_pre", 32'(ready_o), 32'd1);
        tick();
        valid_i = 1'b0;
        check("mulh_busy_ready", 32'(ready_o),  32'd0);
        check("mulh_busy_valid", 32'(valid_ro), 32'd0);
        tick();
        check("mulh_valid",  32'(valid_ro), 32'd1);
        check("mulh_result", result_ro,     32'hFFFF_FFFF);
        check("mulh_ready",  32'(ready_o),  32'd1);
        set_in(1'b1, 32'h304, 32'h022081B3, 32'hFFFF_FFFF, 32'd2);
        repeat (2) tick();
        valid_i = 1'b0;
        check("mul_result", result_ro, 32'hFFFF_FFFE);
        set_in(1'b1, 32'h308, 32'h022081B3, 32'd3, 32'd4);
        tick();
        valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("mul_rst_valid", 32'(valid_ro), 32'd0);
        check("mul_rst_ready", 32'(ready_o),  32'd1);
        rst = 1'b0;
        tick();
        check("mul_rst_dropped", 32'(valid_ro), 32'd0);
`else
        set_in(1'b1, 32'h300, 32'h022091B3, 32'hFFFF_FFFF, 32'd2);
        tick();
        valid_i = 1'b0;
        check("mulh_disabled_illegal", 32'(illegal_ro), 32'd1);
        check("mulh_disabled_valid",   32'(valid_ro),   32'd1);
`endif

        // Randomized traffic against the reference model
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            r_pc = $urandom;
            r_a  = $urandom;
            r_pc[1:0] = 2'b00;
            set_in(($urandom_range(0, 3) != 0), r_pc, gen_inst(), r_a,
                   ($urandom_range(0, 3) == 0) ? r_a : 32'($urandom));
            ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (6) tick();
        mon_en = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
